// File: rtl/sad_pkg.sv
// Shared SAD pipeline definitions: default datapath widths, tracker state encoding,
// and a helper that sizes counters so that a dimension of 1 still gets a 1-bit field.
package sad_pkg;

    localparam int SAD_W_DEF = 32;
    localparam int IDX_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DONE  = 2'd2,
        DRAIN = 2'd3
    } trk_state_e;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sad_rowcol_counter.sv
// Arrival-position counter for one search window: col wraps at WIN_COLS-1 and carries into row.
// Zero latency on last (combinational from the registered position); no backpressure of its own.
module sad_rowcol_counter
    import sad_pkg::*;
#(
    parameter int WIN_COLS = 49,
    parameter int WIN_ROWS = 49,
    localparam int ROW_W   = cnt_w(WIN_ROWS),
    localparam int COL_W   = cnt_w(WIN_COLS)
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             clear,
    input  logic             inc,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             last
);

    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             col_end;
    logic             row_end;

    assign col_end = (col_q == COL_W'(WIN_COLS - 1));
    assign row_end = (row_q == ROW_W'(WIN_ROWS - 1));

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clear) begin
            row_d = '0;
            col_d = '0;
        end else if (inc) begin
            if (col_end) begin
                col_d = '0;
                row_d = row_end ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row  = row_q;
    assign col  = col_q;
    assign last = row_end & col_end;

endmodule

// File: rtl/sad_min_tracker.sv
// Running-minimum best-match tracker over one search window; result 1 cycle after the last accept,
// held with best_* stable until out_ready; in_ready low outside SCAN/DRAIN. Option: SAD_ZERO_EXIT_EN.
module sad_min_tracker
    import sad_pkg::*;
#(
    parameter int SAD_W    = SAD_W_DEF,
    parameter int IDX_W    = IDX_W_DEF,
    parameter int WIN_COLS = 49,
    parameter int WIN_ROWS = 49,
    localparam int ROW_W   = cnt_w(WIN_ROWS),
    localparam int COL_W   = cnt_w(WIN_COLS)
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SAD_W-1:0] in_sad,
    input  logic [IDX_W-1:0] in_index,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SAD_W-1:0] best_sad,
    output logic [IDX_W-1:0] best_index,
    output logic [ROW_W-1:0] best_row,
    output logic [COL_W-1:0] best_col,
    output logic             busy
);

    localparam int NUM_CAND = WIN_COLS * WIN_ROWS;

    trk_state_e       state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic [SAD_W-1:0] best_sad_q, best_sad_d;
    logic [IDX_W-1:0] best_index_q, best_index_d;
    logic [ROW_W-1:0] best_row_q, best_row_d;
    logic [COL_W-1:0] best_col_q, best_col_d;
`ifdef SAD_ZERO_EXIT_EN
    logic             drain_done_q, drain_done_d;
`endif

    logic             accept;
    logic             cnt_clear;
    logic             cnt_last;
    logic [ROW_W-1:0] cnt_row;
    logic [COL_W-1:0] cnt_col;
    logic             is_first;
    logic             take_new;

    assign accept    = in_valid & in_ready_q;
    assign cnt_clear = (state_q == IDLE) & start;

    sad_rowcol_counter #(
        .WIN_COLS (WIN_COLS),
        .WIN_ROWS (WIN_ROWS)
    ) u_pos (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .clear (cnt_clear),
        .inc   (accept),
        .row   (cnt_row),
        .col   (cnt_col),
        .last  (cnt_last)
    );

    // Position (0,0) inside SCAN is always the first beat: the counter clears on start.
    assign is_first = (NUM_CAND == 1) || ((cnt_row == '0) && (cnt_col == '0));
    assign take_new = accept && (state_q == SCAN) && (is_first || (in_sad < best_sad_q));

    always_comb begin
        state_d      = state_q;
        in_ready_d   = in_ready_q;
        out_valid_d  = out_valid_q;
        busy_d       = busy_q;
        best_sad_d   = best_sad_q;
        best_index_d = best_index_q;
        best_row_d   = best_row_q;
        best_col_d   = best_col_q;
`ifdef SAD_ZERO_EXIT_EN
        drain_done_d = drain_done_q;
`endif

        if (take_new) begin
            best_sad_d   = in_sad;
            best_index_d = in_index;
            best_row_d   = cnt_row;
            best_col_d   = cnt_col;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = SCAN;
                    in_ready_d = 1'b1;
                    busy_d     = 1'b1;
                end
            end
            SCAN: begin
                if (accept) begin
                    if (cnt_last) begin
                        state_d     = DONE;
                        in_ready_d  = 1'b0;
                        out_valid_d = 1'b1;
                    end
`ifdef SAD_ZERO_EXIT_EN
                    else if (in_sad == '0) begin
                        state_d      = DRAIN;
                        out_valid_d  = 1'b1;
                        drain_done_d = 1'b0;
                    end
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end
            end
`ifdef SAD_ZERO_EXIT_EN
            // Result handshake and drain completion are independent; leave once both are done.
            DRAIN: begin
                if (accept && cnt_last) begin
                    drain_done_d = 1'b1;
                    in_ready_d   = 1'b0;
                end
                if (out_ready) begin
                    out_valid_d = 1'b0;
                end
                if (drain_done_d && !out_valid_d) begin
                    state_d    = IDLE;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b0;
                end
            end
`endif
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b0;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q      <= IDLE;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            best_sad_q   <= '0;
            best_index_q <= '0;
            best_row_q   <= '0;
            best_col_q   <= '0;
`ifdef SAD_ZERO_EXIT_EN
            drain_done_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            busy_q       <= busy_d;
            best_sad_q   <= best_sad_d;
            best_index_q <= best_index_d;
            best_row_q   <= best_row_d;
            best_col_q   <= best_col_d;
`ifdef SAD_ZERO_EXIT_EN
            drain_done_q <= drain_done_d;
`endif
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign busy       = busy_q;
    assign best_sad   = best_sad_q;
    assign best_index = best_index_q;
    assign best_row   = best_row_q;
    assign best_col   = best_col_q;

endmodule

// File: tb/tb_sad_min_tracker.sv
// Bench for sad_min_tracker on a 3x3 window: directed and randomized windows against a
// prefix-minimum reference model; zero-exit scenario only when SAD_ZERO_EXIT_EN is defined.
module tb_sad_min_tracker;

    localparam int SAD_W = 32;
    localparam int IDX_W = 32;
    localparam int WC    = 3;
    localparam int WR    = 3;
    localparam int NC    = WC * WR;
    localparam int RW    = 2;
    localparam int CW    = 2;

    logic             Clk = 1'b0;
    logic             Rst_n = 1'b0;
    logic             start = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [SAD_W-1:0] in_sad = '0;
    logic [IDX_W-1:0] in_index = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [SAD_W-1:0] best_sad;
    logic [IDX_W-1:0] best_index;
    logic [RW-1:0]    best_row;
    logic [CW-1:0]    best_col;
    logic             busy;

    sad_min_tracker #(
        .SAD_W (SAD_W), .IDX_W (IDX_W), .WIN_COLS (WC), .WIN_ROWS (WR)
    ) dut (
        .Clk (Clk), .Rst_n (Rst_n), .start (start),
        .in_valid (in_valid), .in_ready (in_ready), .in_sad (in_sad), .in_index (in_index),
        .out_valid (out_valid), .out_ready (out_ready),
        .best_sad (best_sad), .best_index (best_index), .best_row (best_row), .best_col (best_col),
        .busy (busy)
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [SAD_W-1:0] sads [NC];
    logic [IDX_W-1:0] idxs [NC];
    int rise_beat;
    bit timed_out;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic start_window();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Expected best beat: earliest strict minimum of the candidates seen before the window closes.
    function automatic void model(output int eb, output int ex);
        eb = 0;
        ex = NC - 1;
        for (int k = 0; k < NC; k++) begin
            if (sads[k] < sads[eb]) eb = k;
`ifdef SAD_ZERO_EXIT_EN
            if (sads[k] == 0) begin
                ex = k;
                break;
            end
`endif
        end
    endfunction

    task automatic feed(input int gap_pct, input bit poke_start);
        rise_beat = -1;
        timed_out = 1'b0;
        for (int k = 0; k < NC; k++) begin
            int w;
            while ($urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
                in_sad   = $urandom;
                in_index = $urandom;
                start    = poke_start;
                tick();
            end
            in_valid = 1'b1;
            in_sad   = sads[k];
            in_index = idxs[k];
            start    = poke_start & $urandom_range(1);
            w = 0;
            while (!in_ready && w < 50) begin
                tick();
                w++;
            end
            if (w >= 50) timed_out = 1'b1;
            tick();
            if (out_valid && rise_beat < 0) rise_beat = k;
        end
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic load_pattern(input int pat [NC]);
        for (int k = 0; k < NC; k++) begin
            sads[k] = SAD_W'(pat[k]);
            idxs[k] = IDX_W'(1000 + k * 7);
        end
    endtask

    task automatic test_reset();
        Rst_n = 1'b0; start = 1'b1; in_valid = 1'b1; in_sad = 32'd3;
        repeat (3) tick();
        n_cmp += 5;
        if (in_ready !== 1'b0)  begin n_bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        if (busy !== 1'b0)      begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        if (best_sad !== '0)    begin n_bad++; $display("FAIL reset_best_sad got=%0d want=0", best_sad); end
        if (best_row !== '0 || best_col !== '0) begin
            n_bad++; $display("FAIL reset_best_pos got=%0d,%0d want=0,0", best_row, best_col);
        end
        Rst_n = 1'b1; start = 1'b0; in_valid = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        int pat [NC] = '{9, 7, 5, 8, 2, 6, 4, 3, 9};
        load_pattern(pat);
        start_window();
        feed(0, 1'b0);
        n_cmp += 5;
        if (rise_beat !== NC - 1) begin n_bad++; $display("FAIL dir_latency got=%0d want=%0d", rise_beat, NC - 1); end
        if (best_sad !== 32'd2)   begin n_bad++; $display("FAIL dir_best_sad got=%0d want=2", best_sad); end
        if (best_index !== idxs[4]) begin n_bad++; $display("FAIL dir_best_index got=%0d want=%0d", best_index, idxs[4]); end
        if (best_row !== 2'd1 || best_col !== 2'd1) begin
            n_bad++; $display("FAIL dir_best_pos got=%0d,%0d want=1,1", best_row, best_col);
        end
        if (in_ready !== 1'b0) begin n_bad++; $display("FAIL dir_in_ready_done got=%b want=0", in_ready); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_bad++; $display("FAIL dir_release got busy=%b ov=%b want 0,0", busy, out_valid);
        end
    endtask

    task automatic test_ties();
        int pat [NC] = '{5, 3, 3, 7, 8, 9, 6, 4, 10};
        load_pattern(pat);
        start_window();
        feed(30, 1'b1);
        n_cmp += 4;
        if (timed_out)             begin n_bad++; $display("FAIL tie_timeout got=1 want=0"); end
        if (best_sad !== 32'd3)    begin n_bad++; $display("FAIL tie_best_sad got=%0d want=3", best_sad); end
        if (best_index !== idxs[1]) begin n_bad++; $display("FAIL tie_best_index got=%0d want=%0d", best_index, idxs[1]); end
        if (best_row !== 2'd0 || best_col !== 2'd1) begin
            n_bad++; $display("FAIL tie_best_pos got=%0d,%0d want=0,1", best_row, best_col);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int eb, ex;
        int bad_cycles;
        for (int k = 0; k < NC; k++) begin
            sads[k] = $urandom | 32'h1;
            idxs[k] = $urandom;
        end
        model(eb, ex);
        start_window();
        feed(10, 1'b0);
        bad_cycles = 0;
        for (int c = 0; c < 10; c++) begin
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || best_sad !== sads[eb] ||
                best_index !== idxs[eb] || best_row !== RW'(eb / WC) || best_col !== CW'(eb % WC))
                bad_cycles++;
            tick();
        end
        n_cmp++;
        if (bad_cycles != 0) begin n_bad++; $display("FAIL bp_hold got=%0d unstable cycles want=0", bad_cycles); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_bad++; $display("FAIL bp_release got busy=%b ov=%b want 0,0", busy, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        start_window();
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_sad = $urandom | 32'h1; in_index = $urandom;
            tick();
        end
        in_valid = 1'b0;
        Rst_n = 1'b0;
        tick();
        Rst_n = 1'b1;
        n_cmp += 3;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL rmid_state got ov=%b busy=%b want 0,0", out_valid, busy);
        end
        if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rmid_in_ready got=%b want=0", in_ready); end
        if (best_sad !== '0)   begin n_bad++; $display("FAIL rmid_best_sad got=%0d want=0", best_sad); end
        for (int k = 0; k < NC; k++) begin
            sads[k] = 32'd1;
            idxs[k] = IDX_W'(50 + k);
        end
        start_window();
        feed(0, 1'b0);
        n_cmp += 3;
        if (rise_beat !== NC - 1) begin n_bad++; $display("FAIL rmid_latency got=%0d want=%0d", rise_beat, NC - 1); end
        if (best_row !== 2'd0 || best_col !== 2'd0) begin
            n_bad++; $display("FAIL rmid_best_pos got=%0d,%0d want=0,0", best_row, best_col);
        end
        if (best_index !== idxs[0]) begin n_bad++; $display("FAIL rmid_best_index got=%0d want=%0d", best_index, idxs[0]); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        for (int w = 0; w < 14; w++) begin
            int eb, ex;
            for (int k = 0; k < NC; k++) begin
                sads[k] = (w % 2 == 1) ? SAD_W'($urandom_range(15)) : $urandom;
                idxs[k] = $urandom;
            end
            model(eb, ex);
            start_window();
            feed($urandom_range(50), 1'b1);
            n_cmp += 6;
            if (timed_out) begin n_bad++; $display("FAIL rnd%0d_timeout got=1 want=0", w); end
            if (rise_beat !== ex) begin n_bad++; $display("FAIL rnd%0d_latency got=%0d want=%0d", w, rise_beat, ex); end
            if (best_sad !== sads[eb]) begin n_bad++; $display("FAIL rnd%0d_best_sad got=%0d want=%0d", w, best_sad, sads[eb]); end
            if (best_index !== idxs[eb]) begin n_bad++; $display("FAIL rnd%0d_best_index got=%0d want=%0d", w, best_index, idxs[eb]); end
            if (best_row !== RW'(eb / WC) || best_col !== CW'(eb % WC)) begin
                n_bad++; $display("FAIL rnd%0d_best_pos got=%0d,%0d want=%0d,%0d", w, best_row, best_col, eb / WC, eb % WC);
            end
            if (busy !== 1'b1) begin n_bad++; $display("FAIL rnd%0d_busy got=%b want=1", w, busy); end
            repeat ($urandom_range(3)) tick();
            // start raised together with out_ready in the result state must be dropped
            out_ready = 1'b1;
            start     = 1'b1;
            tick();
            out_ready = 1'b0;
            start     = 1'b0;
            tick();
            n_cmp++;
            if (busy !== 1'b0 || in_ready !== 1'b0) begin
                n_bad++; $display("FAIL rnd%0d_idle got busy=%b in_ready=%b want 0,0", w, busy, in_ready);
            end
        end
    endtask

`ifdef SAD_ZERO_EXIT_EN
    task automatic test_zero_exit();
        int pat [NC] = '{5, 0, 3, 7, 0, 2, 9, 1, 4};
        load_pattern(pat);
        start_window();
        feed(0, 1'b0);
        n_cmp += 5;
        if (rise_beat !== 1) begin n_bad++; $display("FAIL zx_latency got=%0d want=1", rise_beat); end
        if (timed_out)       begin n_bad++; $display("FAIL zx_drain_accept got=stalled want=all accepted"); end
        if (best_sad !== '0 || best_index !== idxs[1]) begin
            n_bad++; $display("FAIL zx_best got sad=%0d idx=%0d want 0,%0d", best_sad, best_index, idxs[1]);
        end
        if (best_row !== 2'd0 || best_col !== 2'd1) begin
            n_bad++; $display("FAIL zx_best_pos got=%0d,%0d want=0,1", best_row, best_col);
        end
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            n_bad++; $display("FAIL zx_drained got in_ready=%b busy=%b want 0,1", in_ready, busy);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL zx_release got busy=%b want=0", busy); end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_ties();
        test_backpressure();
        test_reset_mid();
        test_random();
`ifdef SAD_ZERO_EXIT_EN
        test_zero_exit();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
